// File: rtl/debouncer_multi_if.sv
// Button/debounce bundle between the raw push-button pins and the control logic.
// "release" is a reserved word in SystemVerilog, so the release pulse is named rel.
interface debouncer_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] rel;
    logic [CHANNELS-1:0] hold;

    modport master (output button, input level, press, rel, hold);
    modport slave  (input button, output level, press, rel, hold);
endinterface

// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability FSM,
// registered press/release pulses and a one-shot long-press pulse.
module debouncer_lane #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int STABLE_COUNT   = 50000,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int HOLD_WIDTH     = 24,
    parameter int HOLD_CYCLES    = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold
);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(HOLD_CYCLES);
    localparam bit                    HOLD_EN  = (HOLD_CYCLES != 0);

    typedef enum logic {STABLE, CONFIRM} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [HOLD_WIDTH-1:0]  hcnt;
    logic                   n;
    logic                   s;

    assign n = raw ^ (BTN_ACTIVE_LOW != 0);
    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= STABLE;
            sync  <= '0;
            cnt   <= '0;
            hcnt  <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], n};
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
            case (state)
                STABLE: begin
                    if (s != level) begin
                        // A one-sample requirement accepts the change immediately.
                        if (CNT_LAST == '0) begin
                            level <= ~level;
                            press <= ~level;
                            rel   <= level;
                        end else begin
                            cnt   <= CNT_WIDTH'(1);
                            state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (s == level) begin
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (cnt == CNT_LAST) begin
                        level <= ~level;
                        press <= ~level;
                        rel   <= level;
                        cnt   <= '0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= STABLE;
                end
            endcase
            // Saturating at HOLD_MAX gives exactly one hold pulse per press.
            if (!level || !HOLD_EN) begin
                hcnt <= '0;
            end else if (hcnt != HOLD_MAX) begin
                hcnt <= hcnt + 1'b1;
                hold <= (hcnt == HOLD_MAX - 1'b1);
            end
        end
    end
endmodule

module debouncer_multi #(
    parameter int CHANNELS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int STABLE_COUNT   = 50000,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int HOLD_WIDTH     = 24,
    parameter int HOLD_CYCLES    = 10000000
) (
    input logic              clk,
    input logic              reset,
    debouncer_multi_if.slave bus
);
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "SYNC_STAGES must be at least 2");
    end
    if (STABLE_COUNT < 1 || longint'(STABLE_COUNT) > (longint'(1) << CNT_WIDTH) - 1) begin : g_bad_stable
        $fatal(1, "STABLE_COUNT does not fit in CNT_WIDTH");
    end
    if (HOLD_CYCLES < 0 || longint'(HOLD_CYCLES) > (longint'(1) << HOLD_WIDTH) - 1) begin : g_bad_hold
        $fatal(1, "HOLD_CYCLES does not fit in HOLD_WIDTH");
    end

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] rel;
    logic [CHANNELS-1:0] hold;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debouncer_lane #(
            .SYNC_STAGES   (SYNC_STAGES),
            .CNT_WIDTH     (CNT_WIDTH),
            .STABLE_COUNT  (STABLE_COUNT),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW),
            .HOLD_WIDTH    (HOLD_WIDTH),
            .HOLD_CYCLES   (HOLD_CYCLES)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .raw  (bus.button[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (rel[i]),
            .hold (hold[i])
        );
    end

    assign bus.level = level;
    assign bus.press = press;
    assign bus.rel   = rel;
    assign bus.hold  = hold;
endmodule

// File: tb/tb_debouncer_multi.sv
// Directed and randomised checks of debouncer_multi against a history-based
// model: a change is accepted once the last STABLE synchronised samples all differ.
module tb_debouncer_multi;
    localparam int CH     = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    debouncer_multi_if #(.CHANNELS(CH)) bus ();

    debouncer_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .CNT_WIDTH(16), .STABLE_COUNT(STABLE),
        .BTN_ACTIVE_LOW(1), .HOLD_WIDTH(24), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [CH-1:0] m_level = '0, m_press = '0, m_rel = '0, m_hold = '0;
    bit            nh [CH][$];   // normalised raw samples of the last SYNC edges
    bit            sq [CH][$];   // synchronised samples seen by the acceptance rule
    int            rise_at [CH];
    int            edge_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit s;
        bit all_diff;
        edge_n++;
        for (int c = 0; c < CH; c++) begin
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_hold[c]  = 1'b0;
            if (!reset) begin
                m_level[c] = 1'b0;
                nh[c] = '{0, 0};
                sq[c].delete();
            end else begin
                s = nh[c][0];
                nh[c].push_back(~bus.button[c]);
                void'(nh[c].pop_front());
                if (m_level[c] && (edge_n - rise_at[c] == HOLD)) m_hold[c] = 1'b1;
                sq[c].push_back(s);
                if (sq[c].size() > STABLE) void'(sq[c].pop_front());
                all_diff = (sq[c].size() == STABLE);
                foreach (sq[c][k]) if (sq[c][k] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = ~m_level[c];
                    m_press[c] = m_level[c];
                    m_rel[c]   = ~m_level[c];
                    if (m_level[c]) rise_at[c] = edge_n;
                    sq[c].delete();
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("m_level", 32'(bus.level), 32'(m_level));
        chk("m_press", 32'(bus.press), 32'(m_press));
        chk("m_rel",   32'(bus.rel),   32'(m_rel));
        chk("m_hold",  32'(bus.hold),  32'(m_hold));
        chk("press_rel_excl", 32'(bus.press & bus.rel), 32'd0);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            nh[c] = '{0, 0};
            rise_at[c] = 0;
        end
        reset = 1'b0;
        bus.button = 2'b11;
        repeat (3) tick();
        chk("reset_out", 32'({bus.level, bus.press, bus.rel, bus.hold}), 32'd0);
        reset = 1'b1;

        // Idle released buttons: nothing moves
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("idle_out", 32'({bus.level, bus.press, bus.rel, bus.hold}), 32'd0);
        end

        // Channel 0 press, held through the hold point, then released
        bus.button[0] = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            chk("p0_level", 32'(bus.level[0]), 32'(t >= 6));
            chk("p0_press", 32'(bus.press[0]), 32'(t == 6));
            chk("p0_hold",  32'(bus.hold[0]),  32'(t == 16));
            chk("p0_ch1",   32'(bus.level[1]), 32'd0);
        end
        bus.button[0] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("r0_rel",   32'(bus.rel[0]),   32'(t == 6));
            chk("r0_level", 32'(bus.level[0]), 32'(t < 6));
        end

        // Glitches of 1..3 samples are rejected; 4 samples are accepted
        for (int k = 1; k <= 4; k++) begin
            bus.button[0] = 1'b0;
            for (int t = 1; t <= 14; t++) begin
                tick();
                if (t == k) bus.button[0] = 1'b1;
                chk("glitch_press", 32'(bus.press[0]), 32'(k == 4 && t == 6));
                chk("glitch_rel",   32'(bus.rel[0]),   32'(k == 4 && t == 10));
            end
        end

        // Simultaneous press, staggered release
        bus.button = 2'b00;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("both_press", 32'(bus.press), (t == 6) ? 32'd3 : 32'd0);
        end
        bus.button[0] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) bus.button[1] = 1'b1;
            chk("stag_rel0", 32'(bus.rel[0]), 32'(t == 6));
            chk("stag_rel1", 32'(bus.rel[1]), 32'(t == 9));
        end
        repeat (4) tick();

        // Reset two samples into CONFIRM with the button still pressed
        bus.button[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            tick();
            chk("rst_mid_out", 32'({bus.level, bus.press, bus.rel, bus.hold}), 32'd0);
        end
        reset = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("rst_repress", 32'(bus.press[0]), 32'(t == 6));
        end

        // Randomised: alternating bouncy and calm phases, rare resets
        for (int ph = 0; ph < 12; ph++) begin
            int rate;
            rate = (ph % 2 == 0) ? 5 : 40;
            for (int t = 0; t < 60; t++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, rate) == 0) bus.button[c] = ~bus.button[c];
                reset = ($urandom_range(0, 150) != 0);
                tick();
            end
        end
        reset = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
